dmem_arbiter: RTL and testbench

Single-port data-memory arbiter between the pipeline MEM stage (core) and an external loader/debug port (ext). Sits between the EX/MEM register outputs (`wr`, `reade`, `addr`, `wr_data`, `func3`) and `datamemory`. The core has priority; ext accesses are granted in idle slots or forced by a starvation guard. While ext owns the port, the arbiter raises `core_stall` to the hazard logic.

---
 rtl/dmem_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the core MEM stage and an ext port.
// Optional starvation guard is enabled by defining DMEM_ARB_STARVE_EN.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int STARVE_LIM = 8,
  parameter int BURST_MAX  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  core_we,
  input  logic                  core_re,
  input  logic [DM_ADDRESS-1:0] core_addr,
  input  logic [DATA_W-1:0]     core_wdata,
  input  logic [2:0]            core_func3,
  output logic [DATA_W-1:0]     core_rdata,
  output logic                  core_stall,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  input  logic [DATA_W-1:0]     ext_wdata,
  output logic                  ext_gnt,
  output logic                  ext_rvalid,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  mem_we,
  output logic                  mem_re,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [2:0]            mem_func3,
  input  logic [DATA_W-1:0]     mem_rd_data
);

  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
  localparam logic [BW-1:0] BURST_LAST = BW'(BURST_MAX - 1);

  typedef enum logic {
    S_CORE = 1'b0,
    S_EXT  = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [BW-1:0]       burst_q, burst_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                core_act;
  logic                force_ext;

  assign core_act   = core_we | core_re;
  assign core_rdata = mem_rd_data;
  assign ext_rvalid = rvalid_q;
  assign ext_rdata  = rdata_q;

`ifdef DMEM_ARB_STARVE_EN
  localparam int SW = (STARVE_LIM > 1) ? $clog2(STARVE_LIM) : 1;
  localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIM - 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force_ext = (starve_q == STARVE_LAST);

  // count consecutive cycles ext is blocked by core traffic
  always_comb begin
    starve_d = '0;
    if (state_q == S_CORE && ext_req && core_act && !force_ext) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // starvation counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  assign force_ext = 1'b0;
`endif

  // ownership decision, port mux and ext read capture
  always_comb begin
    state_d    = state_q;
    burst_d    = burst_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
    mem_we     = core_we;
    mem_re     = core_re;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    mem_func3  = core_func3;
    unique case (state_q)
      S_CORE: begin
        if (ext_req && (!core_act || force_ext)) begin
          state_d = S_EXT;
          burst_d = '0;
        end
      end
      S_EXT: begin
        mem_we     = ext_req & ext_we;
        mem_re     = ext_req & ~ext_we;
        mem_addr   = ext_addr;
        mem_wdata  = ext_wdata;
        mem_func3  = 3'b010;
        ext_gnt    = ext_req;
        core_stall = core_act;
        if (!ext_req) begin
          state_d = S_CORE;
        end else begin
          if (!ext_we) begin
            rvalid_d = 1'b1;
            rdata_d  = mem_rd_data;
          end
          if (burst_q == BURST_LAST) begin
            burst_d = '0;
            if (core_act) begin
              state_d = S_CORE;
            end
          end else begin
            burst_d = burst_q + 1'b1;
          end
        end
      end
    endcase
  end

  // state, burst and read-return registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_CORE;
      burst_q  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table, corner sequences and randomized run
// against a behavioural model of the arbiter.
module tb_dmem_arbiter;

  localparam int SL = 8;
  localparam int BM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_we, core_re;
  logic [8:0]  core_addr;
  logic [31:0] core_wdata;
  logic [2:0]  core_func3;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        ext_req, ext_we;
  logic [8:0]  ext_addr;
  logic [31:0] ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_we, mem_re;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rd_data;

  logic [31:0] bmem [0:127];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = bmem[mem_addr[8:2]];

  always @(posedge clk) begin
    if (mem_we) bmem[mem_addr[8:2]] <= mem_wdata;
  end

  dmem_arbiter #(
    .DATA_W(32), .DM_ADDRESS(9), .STARVE_LIM(SL), .BURST_MAX(BM)
  ) dut (
    .clk(clk), .reset(reset),
    .core_we(core_we), .core_re(core_re), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_func3(core_func3),
    .core_rdata(core_rdata), .core_stall(core_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_gnt(ext_gnt),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_rd_data(mem_rd_data)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    core_we = 0; core_re = 0; core_addr = '0;
    core_wdata = '0; core_func3 = 3'b000;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  // leaves the bench at a negedge with reset low and state fresh
  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    idle_inputs();
    @(negedge clk);
    reset = 0;
  endtask

  typedef struct {
    logic rst, cwe, cre, ereq, ewe;
    logic gnt, stall, mwe, mre, rv, src, chk_rd;
    logic [31:0] rd;
  } vec_t;

  vec_t tv [11];

  // behavioural model state
  bit          m_own;
  int          m_wait, m_burst;
  bit          m_rv;
  logic [31:0] m_rd;
  bit          last_gnt;

  initial begin
    logic [31:0] rd_exp;
    int first;
    int gcnt, scnt;
    for (int i = 0; i < 128; i++) bmem[i] = 32'hA500_0000 | i;
    reset = 1;
    idle_inputs();

    tv[0]  = '{1,0,0,1,1, 0,0,0,0,0,0,1,32'h0};
    tv[1]  = '{0,0,0,1,1, 0,0,0,0,0,0,0,32'h0};
    tv[2]  = '{0,0,0,1,1, 1,0,1,0,0,1,0,32'h0};
    tv[3]  = '{0,0,0,1,0, 1,0,0,1,0,1,0,32'h0};
    tv[4]  = '{0,0,0,0,0, 0,0,0,0,1,1,1,32'hDEADBEEF};
    tv[5]  = '{0,0,0,0,0, 0,0,0,0,0,0,1,32'hDEADBEEF};
    tv[6]  = '{0,0,1,1,0, 0,0,0,1,0,0,0,32'h0};
    tv[7]  = '{0,0,0,1,0, 0,0,0,0,0,0,0,32'h0};
    tv[8]  = '{0,0,1,1,0, 1,1,0,1,0,1,0,32'h0};
    tv[9]  = '{0,0,1,0,0, 0,1,0,0,1,1,1,32'hDEADBEEF};
    tv[10] = '{0,0,1,0,0, 0,0,0,1,0,0,1,32'hDEADBEEF};

    // vector table
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      reset = tv[i].rst;
      core_we = tv[i].cwe; core_re = tv[i].cre;
      core_addr = 9'h044; core_wdata = 32'h1111_1111;
      core_func3 = 3'b001;
      ext_req = tv[i].ereq; ext_we = tv[i].ewe;
      ext_addr = 9'h010; ext_wdata = 32'hDEADBEEF;
      #1;
      chk($sformatf("tv%0d gnt", i), 32'(ext_gnt), 32'(tv[i].gnt));
      chk($sformatf("tv%0d stall", i), 32'(core_stall), 32'(tv[i].stall));
      chk($sformatf("tv%0d mwe", i), 32'(mem_we), 32'(tv[i].mwe));
      chk($sformatf("tv%0d mre", i), 32'(mem_re), 32'(tv[i].mre));
      chk($sformatf("tv%0d rvalid", i), 32'(ext_rvalid), 32'(tv[i].rv));
      chk($sformatf("tv%0d maddr", i), 32'(mem_addr),
          tv[i].src ? 32'h010 : 32'h044);
      chk($sformatf("tv%0d mwdata", i), mem_wdata,
          tv[i].src ? 32'hDEADBEEF : 32'h1111_1111);
      chk($sformatf("tv%0d mf3", i), 32'(mem_func3),
          tv[i].src ? 32'd2 : 32'd1);
      if (tv[i].chk_rd)
        chk($sformatf("tv%0d rdata", i), ext_rdata, tv[i].rd);
      @(negedge clk);
    end

    // starvation under continuous core loads
    do_reset();
    first = 0; gcnt = 0; scnt = 0;
    for (int c = 1; c <= 50; c++) begin
      core_re = 1; core_addr = 9'h020;
      ext_req = 1; ext_we = 0; ext_addr = 9'h030;
      #1;
      if (ext_gnt) gcnt++;
      if (core_stall) scnt++;
      if (ext_gnt && first == 0) first = c;
`ifdef DMEM_ARB_STARVE_EN
      if (c >= 8 && c <= 13)
        chk($sformatf("starve c%0d stall", c), 32'(core_stall),
            32'(c >= 9 && c <= 12));
`endif
      @(negedge clk);
    end
`ifdef DMEM_ARB_STARVE_EN
    chk("starve first_gnt", 32'(first), 32'd9);
`else
    chk("nostarve gnt_cnt", 32'(gcnt), 32'd0);
    chk("nostarve stall_cnt", 32'(scnt), 32'd0);
`endif

    // six-read burst with idle core
    do_reset();
    ext_addr = 9'h040;
    rd_exp = '0;
    for (int c = 1; c <= 8; c++) begin
      ext_req = (c <= 7); ext_we = 0;
      #1;
      chk($sformatf("burst c%0d gnt", c), 32'(ext_gnt),
          32'(c >= 2 && c <= 7));
      chk($sformatf("burst c%0d rvalid", c), 32'(ext_rvalid),
          32'(c >= 3 && c <= 8));
      if (c >= 3) chk($sformatf("burst c%0d rdata", c), ext_rdata, rd_exp);
      if (ext_gnt) begin
        rd_exp = bmem[ext_addr[8:2]];
        @(negedge clk);
        ext_addr = ext_addr + 9'd4;
      end else begin
        @(negedge clk);
      end
    end

    // reset during the second grant of a read burst
    do_reset();
    ext_addr = 9'h060;
    for (int c = 1; c <= 4; c++) begin
      ext_req = 1; ext_we = 0;
      reset = (c == 3);
      if (c == 4) begin
        core_re = 1; core_addr = 9'h0C8; core_func3 = 3'b100;
      end
      #1;
      if (c == 3) chk("rstmid gnt2", 32'(ext_gnt), 32'd1);
      if (c == 4) begin
        chk("rstmid gnt", 32'(ext_gnt), 32'd0);
        chk("rstmid rvalid", 32'(ext_rvalid), 32'd0);
        chk("rstmid stall", 32'(core_stall), 32'd0);
        chk("rstmid mre", 32'(mem_re), 32'd1);
        chk("rstmid mwe", 32'(mem_we), 32'd0);
        chk("rstmid maddr", 32'(mem_addr), 32'h0C8);
        chk("rstmid mf3", 32'(mem_func3), 32'd4);
      end
      @(negedge clk);
    end

    // randomized run against the behavioural model
    do_reset();
    m_own = 0; m_wait = 0; m_burst = 0; m_rv = 0; m_rd = '0;
    last_gnt = 0;
    for (int n = 0; n < 3000; n++) begin
      logic ca, e_gnt, force_in;
      logic [8:0] e_addr;
      reset = ($urandom_range(0, 149) == 0);
      core_we = ($urandom_range(0, 3) == 0);
      core_re = !core_we && ($urandom_range(0, 2) != 0);
      core_addr = 9'($urandom);
      core_wdata = $urandom;
      core_func3 = 3'($urandom);
      if (!ext_req || last_gnt) begin
        ext_req = ($urandom_range(0, 2) != 0);
        ext_we = $urandom_range(0, 1);
        ext_addr = 9'($urandom);
        ext_wdata = $urandom;
      end
      #1;
      ca = core_we | core_re;
      e_gnt = m_own && ext_req;
      e_addr = m_own ? ext_addr : core_addr;
      chk("rnd gnt", 32'(ext_gnt), 32'(e_gnt));
      chk("rnd stall", 32'(core_stall), 32'(m_own && ca));
      chk("rnd mwe", 32'(mem_we),
          32'(m_own ? (ext_req && ext_we) : core_we));
      chk("rnd mre", 32'(mem_re),
          32'(m_own ? (ext_req && !ext_we) : core_re));
      chk("rnd maddr", 32'(mem_addr), 32'(e_addr));
      chk("rnd mwdata", mem_wdata, m_own ? ext_wdata : core_wdata);
      chk("rnd mf3", 32'(mem_func3), m_own ? 32'd2 : 32'(core_func3));
      chk("rnd rvalid", 32'(ext_rvalid), 32'(m_rv));
      chk("rnd rdata", ext_rdata, m_rd);
      chk("rnd crdata", core_rdata, bmem[e_addr[8:2]]);
      last_gnt = ext_gnt;
      if (reset) begin
        m_own = 0; m_wait = 0; m_burst = 0; m_rv = 0; m_rd = '0;
      end else begin
        m_rv = e_gnt && !ext_we;
        if (m_rv) m_rd = bmem[ext_addr[8:2]];
`ifdef DMEM_ARB_STARVE_EN
        force_in = (m_wait >= SL - 1);
`else
        force_in = 0;
`endif
        if (!m_own) begin
          if (ext_req && (!ca || force_in)) begin
            m_own = 1; m_burst = 0; m_wait = 0;
          end else if (ext_req && ca) begin
            m_wait++;
          end else begin
            m_wait = 0;
          end
        end else begin
          m_wait = 0;
          if (!ext_req) begin
            m_own = 0;
          end else begin
            m_burst++;
            if (m_burst == BM) begin
              m_burst = 0;
              if (ca) m_own = 0;
            end
          end
        end
      end
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
